ssp_fifo: RTL and testbench

Parametrised synchronous FIFO for the SSP module's transmit and receive data paths, generalising the fixed 4 x 8 buffer. It provides configurable width and depth and a circular-pointer store. It adds occupancy level, programmable almost-empty/almost-full flags, sticky overflow/underflow error flags, a synchronous flush, and a read-valid strobe. One write port and one read port share a single clock domain.

---
 rtl/ssp_fifo_pkg.sv | 8 +
 rtl/ssp_fifo_mem.sv | 19 +
 rtl/ssp_fifo.sv | 91 +++++++++
 tb/tb_ssp_fifo.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ssp_fifo_pkg.sv
// ssp_fifo_pkg: shared FIFO defaults and the occupancy-counter width helper.
package ssp_fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ssp_fifo_mem.sv
// ssp_fifo_mem: unreset register array, one synchronous write port, one asynchronous read port.
module ssp_fifo_mem
  import ssp_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] wa_i,
  input  logic [WIDTH-1:0]         wd_i,
  input  logic [$clog2(DEPTH)-1:0] ra_i,
  output logic [WIDTH-1:0]         rd_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[wa_i] <= wd_i;
  assign rd_o = mem_q[ra_i];
endmodule

// File: rtl/ssp_fifo.sv
// ssp_fifo: parametrised synchronous FIFO with level, threshold flags, sticky errors, flush and read-valid strobe.
module ssp_fifo
  import ssp_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AE_THRESH = 1,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush,
  input  logic                      write,
  input  logic [WIDTH-1:0]          write_d,
  input  logic                      read,
  output logic [WIDTH-1:0]          read_d,
  output logic                      read_valid,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic                      overflow,
  output logic                      underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic [WIDTH-1:0] read_d_q, read_d_d, mem_rd;
  logic rv_q, rv_d, ovf_q, ovf_d, unf_q, unf_d;
  logic wr_ok, rd_ok, bypass, wr_mem, rd_mem;
  assign empty        = level_q == '0;
  assign full         = level_q == LW'(DEPTH);
  assign almost_empty = int'(level_q) <= AE_THRESH;
  assign almost_full  = int'(level_q) >= AF_THRESH;
  assign wr_ok  = write & (~full | read);
  assign rd_ok  = read & (~empty | write);
  // an empty FIFO hands the incoming word straight to read_d without storing it
  assign bypass = wr_ok & rd_ok & empty;
  assign wr_mem = wr_ok & ~bypass;
  assign rd_mem = rd_ok & ~bypass;
  ssp_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk_i(clk_i),
    .we_i (wr_mem & ~flush),
    .wa_i (wp_q),
    .wd_i (write_d),
    .ra_i (rp_q),
    .rd_o (mem_rd)
  );
  always_comb begin
    wp_d     = wr_mem ? wp_q + AW'(1) : wp_q;
    rp_d     = rd_mem ? rp_q + AW'(1) : rp_q;
    level_d  = level_q + LW'(wr_mem) - LW'(rd_mem);
    read_d_d = bypass ? write_d : rd_mem ? mem_rd : read_d_q;
    rv_d     = rd_ok;
    ovf_d    = ovf_q | (write & ~wr_ok);
    unf_d    = unf_q | (read & ~rd_ok);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q     <= '0;
      rp_q     <= '0;
      level_q  <= '0;
      read_d_q <= '0;
      rv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (flush) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      rv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      level_q  <= level_d;
      read_d_q <= read_d_d;
      rv_q     <= rv_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  assign read_d     = read_d_q;
  assign read_valid = rv_q;
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
endmodule

// File: tb/tb_ssp_fifo.sv
// tb_ssp_fifo: scenario tasks plus randomized traffic checked against a queue-based reference model.
module tb_ssp_fifo;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_i, flush, write, read;
  logic [7:0] write_d, read_d;
  logic read_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] level;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  logic [7:0] m_rd;
  logic m_rv, m_ovf, m_unf;

  ssp_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush(flush), .write(write), .write_d(write_d),
    .read(read), .read_d(read_d), .read_valid(read_valid), .level(level),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_rd = 8'h00; m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // drive one cycle of requests, advance the reference model, then step past the edge
  task automatic cyc(input logic w, input logic [7:0] wd, input logic r, input logic fl);
    int cnt;
    logic wok, rok;
    write = w; write_d = wd; read = r; flush = fl;
    cnt = q.size();
    wok = w && (cnt < DEPTH || r);
    rok = r && (cnt > 0 || w);
    if (fl) begin
      q.delete(); m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (w && !wok) m_ovf = 1'b1;
      if (r && !rok) m_unf = 1'b1;
      m_rv = rok;
      if (rok && cnt == 0) m_rd = wd;
      else begin
        if (rok) m_rd = q.pop_front();
        if (wok) q.push_back(wd);
      end
    end
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; #2;
    n_tests++;
    if ({read_d, read_valid, level, empty, full, almost_empty, almost_full, overflow, underflow} !== {8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_values: got rd=%h rv=%b lvl=%0d e=%b f=%b ae=%b af=%b ovf=%b unf=%b", read_d, read_valid, level, empty, full, almost_empty, almost_full, overflow, underflow);
    end
    @(posedge clk); #1; rst_i = 1'b0; model_reset();
    cyc(1, 8'hC1, 0, 0); cyc(1, 8'hC2, 0, 0); cyc(1, 8'hC3, 0, 0); cyc(0, 0, 1, 0);
    n_tests++;
    if (read_d !== 8'hC1 || level !== 3'd2) begin
      n_fail++; $display("FAIL reset_prep: got rd=%h lvl=%0d want rd=c1 lvl=2", read_d, level);
    end
    #2 rst_i = 1'b1; #1;
    n_tests++;
    if (level !== 3'd0 || empty !== 1'b1 || read_d !== 8'h00) begin
      n_fail++; $display("FAIL reset_async: got lvl=%0d e=%b rd=%h want 0 1 00", level, empty, read_d);
    end
    @(posedge clk); #3 rst_i = 1'b0; model_reset();
    @(posedge clk); #1;
    cyc(0, 0, 1, 0);
    n_tests++;
    if (underflow !== 1'b1 || read_valid !== 1'b0 || read_d !== 8'h00) begin
      n_fail++; $display("FAIL reset_underflow: got unf=%b rv=%b rd=%h want 1 0 00", underflow, read_valid, read_d);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, v[i], 0, 0);
      n_tests++;
      if (level !== 3'(i + 1) || almost_full !== (i >= 2) || full !== (i == 3)) begin
        n_fail++; $display("FAIL fill_%0d: got lvl=%0d af=%b f=%b want lvl=%0d af=%b f=%b", i, level, almost_full, full, i + 1, i >= 2, i == 3);
      end
    end
    cyc(1, 8'h55, 0, 0);
    n_tests++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow: got lvl=%0d ovf=%b want 4 1", level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0);
      n_tests++;
      if (read_d !== v[i] || read_valid !== 1'b1) begin
        n_fail++; $display("FAIL drain_%0d: got rd=%h rv=%b want %h 1", i, read_d, read_valid, v[i]);
      end
    end
    n_tests++;
    if (empty !== 1'b1 || almost_empty !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty: got e=%b ae=%b want 1 1", empty, almost_empty);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want = 8'h01;
    cyc(0, 0, 0, 1);
    cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0);
    for (int i = 3; i <= 10; i++) begin
      cyc(0, 0, 1, 0);
      n_tests++;
      if (read_d !== want || read_valid !== 1'b1) begin
        n_fail++; $display("FAIL wrap_rd_%0d: got %h rv=%b want %h", i, read_d, read_valid, want);
      end
      want++;
      cyc(1, 8'(i), 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 0);
      n_tests++;
      if (read_d !== want) begin
        n_fail++; $display("FAIL wrap_tail_%0d: got %h want %h", i, read_d, want);
      end
      want++;
    end
    n_tests++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL wrap_flags: got ovf=%b unf=%b e=%b want 0 0 1", overflow, underflow, empty);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] v [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    cyc(0, 0, 0, 1);
    cyc(1, 8'hA5, 1, 0);
    n_tests++;
    if (read_d !== 8'hA5 || read_valid !== 1'b1 || level !== 3'd0 || underflow !== 1'b0) begin
      n_fail++; $display("FAIL bypass: got rd=%h rv=%b lvl=%0d unf=%b want a5 1 0 0", read_d, read_valid, level, underflow);
    end
    cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0); cyc(1, 8'h44, 0, 0);
    cyc(1, 8'h66, 1, 0);
    n_tests++;
    if (read_d !== 8'h11 || read_valid !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_rw: got rd=%h rv=%b lvl=%0d ovf=%b want 11 1 4 0", read_d, read_valid, level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0);
      n_tests++;
      if (read_d !== v[i] || read_valid !== 1'b1) begin
        n_fail++; $display("FAIL full_rw_drain_%0d: got %h rv=%b want %h", i, read_d, read_valid, v[i]);
      end
    end
  endtask

  task automatic test_underflow_flush();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    n_tests++;
    if (read_d !== 8'h66 || read_valid !== 1'b0 || underflow !== 1'b1) begin
      n_fail++; $display("FAIL underflow: got rd=%h rv=%b unf=%b want 66 0 1", read_d, read_valid, underflow);
    end
    cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0); cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h77, 0, 1);
    n_tests++;
    if (level !== 3'd0 || underflow !== 1'b0 || read_d !== 8'h66 || empty !== 1'b1) begin
      n_fail++; $display("FAIL flush: got lvl=%0d unf=%b rd=%h e=%b want 0 0 66 1", level, underflow, read_d, empty);
    end
    cyc(0, 0, 1, 0);
    n_tests++;
    if (read_valid !== 1'b0 || underflow !== 1'b1 || read_d !== 8'h66) begin
      n_fail++; $display("FAIL flush_nostore: got rv=%b unf=%b rd=%h want 0 1 66", read_valid, underflow, read_d);
    end
  endtask

  task automatic test_random();
    int sz;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
      sz = q.size();
      n_tests++;
      if ({read_d, read_valid, level, overflow, underflow} !== {m_rd, m_rv, 3'(sz), m_ovf, m_unf} ||
          {empty, full, almost_empty, almost_full} !== {sz == 0, sz == DEPTH, sz <= 1, sz >= DEPTH - 1}) begin
        n_fail++;
        $display("FAIL random_%0d: got rd=%h rv=%b lvl=%0d ovf=%b unf=%b e=%b f=%b ae=%b af=%b want rd=%h rv=%b lvl=%0d ovf=%b unf=%b",
                 i, read_d, read_valid, level, overflow, underflow, empty, full, almost_empty, almost_full, m_rd, m_rv, sz, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    flush = 1'b0; write = 1'b0; read = 1'b0; write_d = 8'h00;
    model_reset();
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_simultaneous();
    test_underflow_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
